// File: rtl/memory_master_pkg.sv
// Shared types and default widths for the memory_master initiator.
package memory_master_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_LEN_W  = 4;

  // Controller states: idle, write streaming, and the three-step read sequence.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD_ADDR = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RD_RSP  = 3'd4
  } state_t;

endpackage

// File: rtl/memory_master_addr_gen.sv
// Burst address and beat counter: loads on command accept, steps once per
// non-final beat. Address wraps modulo the memory depth; the counter saturates at 0.
module memory_master_addr_gen
  import memory_master_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_advance,
  output logic [ADDR_W-1:0] o_addr,
  output logic [LEN_W-1:0]  o_beats,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_beats;

  // Load start address / remaining beats, or step to the next beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_beats <= '0;
    end else if (i_load) begin
      r_addr  <= i_addr;
      r_beats <= i_len;
    end else if (i_advance && (r_beats != '0)) begin
      r_addr  <= r_addr + 1'b1;
      r_beats <= r_beats - 1'b1;
    end
  end

  assign o_addr  = r_addr;
  assign o_beats = r_beats;
  assign o_last  = (r_beats == '0);

endmodule

// File: rtl/memory_master.sv
// Burst initiator for a clocked single-port memory with a one-cycle registered read.
// Write beats pass straight through to the memory on handshake; read beats are
// fetched one at a time (address, wait, respond) and held until consumed.
module memory_master
  import memory_master_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              busy,
  output logic              mem_read_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  state_t            r_state;
  state_t            w_state_next;
  logic              w_load;
  logic              w_advance;
  logic              w_last;
  logic [ADDR_W-1:0] w_addr;
  logic [LEN_W-1:0]  w_beats;
  logic              w_wr_hs;
  logic              w_rsp_hs;
  logic              r_rsp_valid;
  logic              r_rsp_last;
  logic [DATA_W-1:0] r_rsp_data;

  memory_master_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_load),
    .i_addr    (cmd_addr),
    .i_len     (cmd_len),
    .i_advance (w_advance),
    .o_addr    (w_addr),
    .o_beats   (w_beats),
    .o_last    (w_last)
  );

  assign w_wr_hs  = (r_state == ST_WR) && wr_valid;
  assign w_rsp_hs = (r_state == ST_RD_RSP) && r_rsp_valid && rsp_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state, command load and beat-advance decisions.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_advance    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_load       = 1'b1;
          w_state_next = cmd_write ? ST_WR : ST_RD_ADDR;
        end
      end
      ST_WR: begin
        if (w_wr_hs) begin
          if (w_last) w_state_next = ST_IDLE;
          else        w_advance    = 1'b1;
        end
      end
      ST_RD_ADDR: w_state_next = ST_RD_WAIT;
      ST_RD_WAIT: w_state_next = ST_RD_RSP;
      ST_RD_RSP: begin
        if (w_rsp_hs) begin
          if (r_rsp_last) begin
            w_state_next = ST_IDLE;
          end else begin
            w_advance    = 1'b1;
            w_state_next = ST_RD_ADDR;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Response register: capture the memory's registered read, hold until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_last  <= 1'b0;
      r_rsp_data  <= '0;
    end else if (r_state == ST_RD_WAIT) begin
      r_rsp_valid <= 1'b1;
      r_rsp_last  <= w_last;
      r_rsp_data  <= mem_data_out;
    end else if (w_rsp_hs) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign cmd_ready      = (r_state == ST_IDLE);
  assign wr_ready       = (r_state == ST_WR);
  assign busy           = (r_state != ST_IDLE);
  assign rsp_valid      = r_rsp_valid;
  assign rsp_last       = r_rsp_last;
  assign rsp_data       = r_rsp_data;
  // Only a write beat handshake writes; every other cycle is a harmless read.
  assign mem_read_write = w_wr_hs;
  assign mem_address    = w_addr;
  assign mem_data_in    = wr_data;

endmodule

// File: tb/tb_memory_master.sv
// Bench for memory_master: behavioural single-port memory, shadow-memory
// scoreboard for read beats, directed write/read/stall/reset scenarios.
module tb_memory_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [3:0] cmd_addr, cmd_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rsp_valid, rsp_ready, rsp_last;
  logic [7:0] rsp_data;
  logic       busy, mem_read_write;
  logic [3:0] mem_address;
  logic [7:0] mem_data_in, mem_data_out;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] shadow [16];
  logic [7:0] tb_mem [16];
  logic [7:0] wdata  [16];
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  memory_master dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_addr       (cmd_addr),
    .cmd_len        (cmd_len),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_data        (wr_data),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_last       (rsp_last),
    .busy           (busy),
    .mem_read_write (mem_read_write),
    .mem_address    (mem_address),
    .mem_data_in    (mem_data_in),
    .mem_data_out   (mem_data_out)
  );

  // Behavioural memory: write on read_write=1, registered read otherwise.
  always @(posedge clk) begin
    if (mem_read_write) tb_mem[mem_address] <= mem_data_in;
    mem_data_out <= tb_mem[mem_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: a read beat handshake seen at negedge completes at the next posedge.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_data), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("rsp beat data=%02h last=%0d (expect %02h/%0d)", rsp_data, rsp_last, e.data, e.last);
        chk("rsp_data", 32'(rsp_data), 32'(e.data));
        chk("rsp_last", 32'(rsp_last), 32'(e.last));
      end
    end
  end

  task automatic send_cmd(input logic w, input logic [3:0] a, input logic [3:0] l);
    int n;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("cmd_accept_timeout", 32'(n < 100), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    $display("cmd write=%0d addr=%0d len=%0d accepted", w, a, l);
  endtask

  task automatic push_read(input logic [3:0] a, input logic [3:0] l);
    exp_t e;
    logic [3:0] p;
    p = a;
    for (int i = 0; i <= int'(l); i++) begin
      e.data = shadow[p];
      e.last = (i == int'(l));
      exp_q.push_back(e);
      p = p + 4'd1;
    end
  endtask

  // Stream n write beats (from wdata) with 'gap' idle cycles before each beat.
  task automatic wr_beats(input logic [3:0] start, input int n, input int gap);
    logic [3:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) begin
        wr_valid = 1'b0;
        @(negedge clk);
        chk("gap_mem_rw", 32'(mem_read_write), 32'd0);
        chk("gap_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
      end
      wr_valid = 1'b1;
      wr_data  = wdata[i];
      @(negedge clk);
      chk("wr_ready", 32'(wr_ready), 32'd1);
      chk("hs_mem_rw", 32'(mem_read_write), 32'd1);
      chk("hs_mem_addr", 32'(mem_address), 32'(a));
      chk("hs_mem_din", 32'(mem_data_in), 32'(wdata[i]));
      chk("hs_cmd_ready", 32'(cmd_ready), 32'd0);
      @(posedge clk);
      shadow[a] = wdata[i];
      $display("wr beat addr=%0d data=%02h", a, wdata[i]);
      a = a + 4'd1;
      #1;
    end
    wr_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < 200), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string phase);
    chk({phase, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({phase, "_wr_ready"},  32'(wr_ready),  32'd0);
    chk({phase, "_busy"},      32'(busy),      32'd0);
    chk({phase, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({phase, "_rsp_last"},  32'(rsp_last),  32'd0);
    chk({phase, "_rsp_data"},  32'(rsp_data),  32'd0);
    chk({phase, "_mem_rw"},    32'(mem_read_write), 32'd0);
    chk({phase, "_mem_addr"},  32'(mem_address),    32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin shadow[i] = 8'h00; wdata[i] = 8'h00; end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("rst");
    @(posedge clk); #1;

    // Single write then single read, with read latency check.
    wdata[0] = 8'hA5;
    send_cmd(1'b1, 4'd3, 4'd0);
    wr_beats(4'd3, 1, 0);
    @(negedge clk);
    chk("t1_idle_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    send_cmd(1'b0, 4'd3, 4'd0);
    push_read(4'd3, 4'd0);
    @(negedge clk); chk("lat_c0_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk); chk("lat_c1_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk); chk("lat_c2_valid", 32'(rsp_valid), 32'd1);
    drain();

    // Wrapping 4-beat write at the top of the address space, then read back.
    wdata[0] = 8'h11; wdata[1] = 8'h22; wdata[2] = 8'h33; wdata[3] = 8'h44;
    send_cmd(1'b1, 4'd14, 4'd3);
    wr_beats(4'd14, 4, 0);
    @(negedge clk);
    chk("wrap_mem14", 32'(tb_mem[14]), 32'h11);
    chk("wrap_mem15", 32'(tb_mem[15]), 32'h22);
    chk("wrap_mem0",  32'(tb_mem[0]),  32'h33);
    chk("wrap_mem1",  32'(tb_mem[1]),  32'h44);
    @(posedge clk); #1;
    send_cmd(1'b0, 4'd14, 4'd3);
    push_read(4'd14, 4'd3);
    drain();

    // Read with consumer back-pressure: beat must hold and address must not move.
    rsp_ready = 1'b0;
    send_cmd(1'b0, 4'd14, 4'd1);
    push_read(4'd14, 4'd1);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin n++; @(negedge clk); end
    chk("stall_valid_timeout", 32'(n < 20), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_data",  32'(rsp_data),  32'h11);
      chk("stall_last",  32'(rsp_last),  32'd0);
      chk("stall_addr",  32'(mem_address), 32'd14);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drain();

    // Write burst with wr_valid gaps, then read back.
    wdata[0] = 8'h5A; wdata[1] = 8'h6B; wdata[2] = 8'h7C;
    send_cmd(1'b1, 4'd6, 4'd2);
    wr_beats(4'd6, 3, 2);
    @(negedge clk);
    chk("gap_done_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    send_cmd(1'b0, 4'd6, 4'd2);
    push_read(4'd6, 4'd2);
    drain();

    // Reset asserted during beat 2 of a 4-beat write.
    wdata[0] = 8'h50; wdata[1] = 8'h51; wdata[2] = 8'h52; wdata[3] = 8'h53;
    send_cmd(1'b1, 4'd8, 4'd3);
    wr_beats(4'd8, 4, 0);
    @(posedge clk); #1;
    wdata[0] = 8'hC0; wdata[1] = 8'hC1; wdata[2] = 8'hC2; wdata[3] = 8'hC3;
    send_cmd(1'b1, 4'd8, 4'd3);
    wr_beats(4'd8, 2, 0);
    wr_valid = 1'b1;
    wr_data  = 8'hC2;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    @(posedge clk); #1;
    wr_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    chk("midrst_mem8",  32'(tb_mem[8]),  32'hC0);
    chk("midrst_mem9",  32'(tb_mem[9]),  32'hC1);
    chk("midrst_mem10", 32'(tb_mem[10]), 32'h52);
    chk("midrst_mem11", 32'(tb_mem[11]), 32'h53);
    chk("midrst_idle",  32'(busy), 32'd0);
    @(posedge clk); #1;
    send_cmd(1'b0, 4'd8, 4'd3);
    push_read(4'd8, 4'd3);
    drain();

    // cmd_valid held high through a write burst: next command waits for IDLE.
    wdata[0] = 8'hD1; wdata[1] = 8'hD2;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd4; cmd_len = 4'd1;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin n++; @(negedge clk); end
    chk("held_accept_timeout", 32'(n < 100), 32'd1);
    @(posedge clk); #1;
    cmd_write = 1'b0; cmd_addr = 4'd4; cmd_len = 4'd0;
    wr_beats(4'd4, 2, 1);
    @(negedge clk);
    chk("held_idle_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("held_idle_busy", 32'(busy), 32'd0);
    push_read(4'd4, 4'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("held_accepted_busy", 32'(busy), 32'd1);
    chk("held_accepted_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("held_accepted_addr", 32'(mem_address), 32'd4);
    chk("held_accepted_rw", 32'(mem_read_write), 32'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
